// File: rtl/adc_acq_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : adc_acq_sequencer_if
//  Description : Control/status bundle between the ADC acquisition sequencer
//                and the surrounding system.
//                  enable, clr_err            : run control and error clear
//                  adc_cnv, ADC_clock,
//                  ADC_word_sync_n            : ADC / deserializer timing
//                  sample_valid, busy         : frame status
//                  overrun, overrun_cnt       : missed-period reporting
//                  sample_cnt                 : completed frame count
//                master = sequencer side, slave = consumer/controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_acq_sequencer_if;
  logic        enable;
  logic        clr_err;
  logic        adc_cnv;
  logic        ADC_clock;
  logic        ADC_word_sync_n;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic [15:0] overrun_cnt;
  logic [31:0] sample_cnt;

  modport master (
    input  enable, clr_err,
    output adc_cnv, ADC_clock, ADC_word_sync_n, sample_valid,
           busy, overrun, overrun_cnt, sample_cnt
  );

  modport slave (
    output enable, clr_err,
    input  adc_cnv, ADC_clock, ADC_word_sync_n, sample_valid,
           busy, overrun, overrun_cnt, sample_cnt
  );
endinterface
`default_nettype wire

// File: rtl/adc_acq_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : adc_acq_sequencer
//  Description : Timing master for one serial ADC channel. Every
//                SAMPLE_PERIOD cycles it strobes adc_cnv, waits out the
//                conversion, bursts N_BITS/2 periods of ADC_clock, pulses
//                ADC_word_sync_n low and then issues a one-cycle
//                sample_valid. Period ticks arriving mid-frame are dropped
//                and reported as overruns.
//  Ports       : clk   - system clock, all outputs registered on rising edge
//                rst_n - asynchronous active-low reset
//                bus   - adc_acq_sequencer_if.master (control, ADC timing,
//                        status and counters)
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_acq_sequencer #(
  parameter int CNV_HIGH      = 4,
  parameter int CONV_CYCLES   = 60,
  parameter int SCLK_DIV      = 2,
  parameter int N_BITS        = 18,
  parameter int SYNC_LOW      = 2,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adc_acq_sequencer_if.master   bus
);

  localparam int c_SHIFT_LEN = N_BITS * SCLK_DIV;
  localparam int c_PH_MAX_A  = (CNV_HIGH > CONV_CYCLES) ? CNV_HIGH : CONV_CYCLES;
  localparam int c_PH_MAX_B  = (c_SHIFT_LEN > SYNC_LOW) ? c_SHIFT_LEN : SYNC_LOW;
  localparam int c_PH_MAX    = (c_PH_MAX_A > c_PH_MAX_B) ? c_PH_MAX_A : c_PH_MAX_B;
  localparam int c_CW        = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;
  localparam int c_PW        = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int c_DW        = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  localparam logic [c_CW-1:0] c_CNV_LAST   = c_CW'(CNV_HIGH - 1);
  localparam logic [c_CW-1:0] c_CONV_LAST  = c_CW'(CONV_CYCLES - 1);
  localparam logic [c_CW-1:0] c_SHIFT_LAST = c_CW'(c_SHIFT_LEN - 1);
  localparam logic [c_CW-1:0] c_SYNC_LAST  = c_CW'(SYNC_LOW - 1);
  localparam logic [c_PW-1:0] c_PER_LAST   = c_PW'(SAMPLE_PERIOD - 1);
  localparam logic [c_DW-1:0] c_DIV_LAST   = c_DW'(SCLK_DIV - 1);

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_CONVERT   = 3'd1;
  localparam logic [2:0] c_ST_WAIT_CONV = 3'd2;
  localparam logic [2:0] c_ST_SHIFT     = 3'd3;
  localparam logic [2:0] c_ST_SYNC      = 3'd4;

  logic [c_PW-1:0] r_period_cnt;
  logic [2:0]      r_state;
  logic [c_CW-1:0] r_cnt;
  logic [c_DW-1:0] r_div;
  logic            r_start;
  logic            r_adc_cnv;
  logic            r_sclk;
  logic            r_sync_n;
  logic            r_valid;
  logic            r_busy;
  logic            r_overrun;
  logic [15:0]     r_overrun_cnt;
  logic [31:0]     r_sample_cnt;

  logic            w_tick;
  logic            w_overrun_evt;
  logic [2:0]      w_state_nxt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic [c_DW-1:0] w_div_nxt;
  logic            w_start_nxt;
  logic            w_adc_cnv_nxt;
  logic            w_sclk_nxt;
  logic            w_sync_n_nxt;
  logic            w_valid_nxt;
  logic            w_busy_nxt;

  // Sample-period timebase; parked at zero while stopped so that the first
  // enabled cycle is always a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else if (!bus.enable || (r_period_cnt == c_PER_LAST)) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + 1'b1;
    end
  end

  assign w_tick = bus.enable && (r_period_cnt == '0);

  // r_start covers the single cycle between accepting a tick and entering
  // CONVERT, so that cycle is also treated as "frame in progress".
  assign w_overrun_evt = w_tick && ((r_state != c_ST_IDLE) || r_start);

  // State, phase counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_IDLE;
      r_cnt        <= '0;
      r_div        <= '0;
      r_start      <= 1'b0;
      r_adc_cnv    <= 1'b0;
      r_sclk       <= 1'b0;
      r_sync_n     <= 1'b1;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_start   <= w_start_nxt;
      r_adc_cnv <= w_adc_cnv_nxt;
      r_sclk    <= w_sclk_nxt;
      r_sync_n  <= w_sync_n_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      if (w_valid_nxt) begin
        r_sample_cnt <= r_sample_cnt + 1'b1;
      end
    end
  end

  // Next-state and phase-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_start_nxt = 1'b0;
    w_div_nxt   = '0;
    case (r_state)
      c_ST_IDLE: begin
        w_cnt_nxt = '0;
        if (r_start) begin
          w_state_nxt = c_ST_CONVERT;
        end else begin
          w_start_nxt = w_tick;
        end
      end
      c_ST_CONVERT: begin
        if (r_cnt == c_CNV_LAST) begin
          w_state_nxt = c_ST_WAIT_CONV;
          w_cnt_nxt   = '0;
        end
      end
      c_ST_WAIT_CONV: begin
        if (r_cnt == c_CONV_LAST) begin
          w_state_nxt = c_ST_SHIFT;
          w_cnt_nxt   = '0;
        end
      end
      c_ST_SHIFT: begin
        if (r_div != c_DIV_LAST) begin
          w_div_nxt = r_div + 1'b1;
        end
        if (r_cnt == c_SHIFT_LAST) begin
          w_state_nxt = c_ST_SYNC;
          w_cnt_nxt   = '0;
        end
      end
      c_ST_SYNC: begin
        if (r_cnt == c_SYNC_LAST) begin
          w_state_nxt = c_ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register. ADC_clock starts high on SHIFT entry and toggles
  // at the end of every SCLK_DIV-cycle half period; with an even N_BITS the
  // final half period is low, so the burst ends low without a runt.
  always_comb begin
    w_adc_cnv_nxt = (w_state_nxt == c_ST_CONVERT);
    w_sync_n_nxt  = (w_state_nxt != c_ST_SYNC);
    w_busy_nxt    = (w_state_nxt != c_ST_IDLE);
    w_valid_nxt   = (r_state == c_ST_SYNC) && (w_state_nxt == c_ST_IDLE);
    w_sclk_nxt    = 1'b0;
    if (w_state_nxt == c_ST_SHIFT) begin
      if (r_state != c_ST_SHIFT) begin
        w_sclk_nxt = 1'b1;
      end else if (r_div == c_DIV_LAST) begin
        w_sclk_nxt = ~r_sclk;
      end else begin
        w_sclk_nxt = r_sclk;
      end
    end
  end

  // Overrun reporting; a clear in the same cycle as an event takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun     <= 1'b0;
      r_overrun_cnt <= '0;
    end else if (bus.clr_err) begin
      r_overrun     <= 1'b0;
      r_overrun_cnt <= '0;
    end else if (w_overrun_evt) begin
      r_overrun <= 1'b1;
      if (r_overrun_cnt != 16'hFFFF) begin
        r_overrun_cnt <= r_overrun_cnt + 1'b1;
      end
    end
  end

  assign bus.adc_cnv         = r_adc_cnv;
  assign bus.ADC_clock       = r_sclk;
  assign bus.ADC_word_sync_n = r_sync_n;
  assign bus.sample_valid    = r_valid;
  assign bus.busy            = r_busy;
  assign bus.overrun         = r_overrun;
  assign bus.overrun_cnt     = r_overrun_cnt;
  assign bus.sample_cnt      = r_sample_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_acq_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_adc_acq_sequencer
//  Description : Self-checking bench for adc_acq_sequencer. Three instances:
//                u_dut (defaults), u_ovr (SAMPLE_PERIOD=50) and u_fast
//                (SCLK_DIV=1). Expected sample_valid events are queued when
//                enable is driven and matched when the instance fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_acq_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_acq_sequencer_if if_dut ();
  adc_acq_sequencer_if if_ovr ();
  adc_acq_sequencer_if if_fast ();

  adc_acq_sequencer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_dut)
  );

  adc_acq_sequencer #(.SAMPLE_PERIOD(50)) u_ovr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_ovr)
  );

  adc_acq_sequencer #(.SCLK_DIV(1)) u_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_fast)
  );

  typedef struct {
    int dut;
    int edge_n;
    int cnt;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int d, input int e, input int c);
    exp_t t;
    t.dut    = d;
    t.edge_n = e;
    t.cnt    = c;
    sb_q.push_back(t);
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int n);
    tick_to(n);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mon_cnt(input int i);
    case (i)
      0:       return if_dut.sample_cnt;
      1:       return if_ovr.sample_cnt;
      default: return if_fast.sample_cnt;
    endcase
  endfunction

  // Edge counters for ADC_clock and adc_cnv.
  int   rises_dut = 0;
  int   rises_fast = 0;
  int   cnv_rises_dut = 0;
  logic prev_sclk_dut = 1'b0;
  logic prev_sclk_fast = 1'b0;
  logic prev_cnv_dut = 1'b0;

  always @(negedge clk) begin
    if (if_dut.ADC_clock && !prev_sclk_dut)   rises_dut <= rises_dut + 1;
    if (if_fast.ADC_clock && !prev_sclk_fast) rises_fast <= rises_fast + 1;
    if (if_dut.adc_cnv && !prev_cnv_dut)      cnv_rises_dut <= cnv_rises_dut + 1;
    prev_sclk_dut  <= if_dut.ADC_clock;
    prev_sclk_fast <= if_fast.ADC_clock;
    prev_cnv_dut   <= if_dut.adc_cnv;
  end

  // Scoreboard: each sample_valid consumes the oldest entry for its instance.
  wire [2:0] w_valid = {if_fast.sample_valid, if_ovr.sample_valid, if_dut.sample_valid};

  always @(negedge clk) begin : p_sb
    int idx;
    for (int i = 0; i < 3; i++) begin
      if (w_valid[i] === 1'b1) begin
        idx = -1;
        for (int j = 0; j < sb_q.size(); j++) begin
          if (idx < 0 && sb_q[j].dut == i) idx = j;
        end
        if (idx < 0) begin
          chk($sformatf("sb_unexpected_valid_inst%0d", i), cyc, 32'hFFFF_FFFF);
        end else begin
          chk($sformatf("sb_valid_edge_inst%0d", i), cyc, sb_q[idx].edge_n);
          chk($sformatf("sb_sample_cnt_inst%0d", i), mon_cnt(i), sb_q[idx].cnt);
          sb_q.delete(idx);
        end
      end
    end
  end

  initial begin
    if_dut.enable  = 1'b0; if_dut.clr_err  = 1'b0;
    if_ovr.enable  = 1'b0; if_ovr.clr_err  = 1'b0;
    if_fast.enable = 1'b0; if_fast.clr_err = 1'b0;

    // Reset values
    at_neg(2);
    chk("rst_adc_cnv",      if_dut.adc_cnv, 0);
    chk("rst_ADC_clock",    if_dut.ADC_clock, 0);
    chk("rst_sync_n",       if_dut.ADC_word_sync_n, 1);
    chk("rst_sample_valid", if_dut.sample_valid, 0);
    chk("rst_busy",         if_dut.busy, 0);
    chk("rst_overrun",      if_dut.overrun, 0);
    chk("rst_overrun_cnt",  if_dut.overrun_cnt, 0);
    chk("rst_sample_cnt",   if_dut.sample_cnt, 0);
    tick_to(3);
    rst_n = 1'b1;

    // All three instances see enable first at edge 10
    tick_to(9);
    if_dut.enable  = 1'b1;
    if_ovr.enable  = 1'b1;
    if_fast.enable = 1'b1;
    for (int k = 0; k < 5; k++) push_exp(0, 113 + 200 * k, k + 1);
    push_exp(1, 113, 1);
    push_exp(1, 263, 2);
    push_exp(2, 95, 1);

    at_neg(10);
    chk("dut_adc_cnv@10", if_dut.adc_cnv, 0);
    chk("dut_busy@10",    if_dut.busy, 0);
    at_neg(11);
    chk("dut_adc_cnv@11", if_dut.adc_cnv, 1);
    chk("dut_busy@11",    if_dut.busy, 1);
    at_neg(14);
    chk("dut_adc_cnv@14", if_dut.adc_cnv, 1);
    at_neg(15);
    chk("dut_adc_cnv@15", if_dut.adc_cnv, 0);
    at_neg(59);
    chk("ovr_overrun@59", if_ovr.overrun, 0);
    at_neg(60);
    chk("ovr_overrun@60",     if_ovr.overrun, 1);
    chk("ovr_overrun_cnt@60", if_ovr.overrun_cnt, 1);
    at_neg(74);
    chk("dut_sclk@74", if_dut.ADC_clock, 0);
    at_neg(75);
    chk("dut_sclk@75",  if_dut.ADC_clock, 1);
    chk("fast_sclk@75", if_fast.ADC_clock, 1);
    at_neg(76);
    chk("fast_sclk@76", if_fast.ADC_clock, 0);
    chk("dut_sclk@76",  if_dut.ADC_clock, 1);
    at_neg(77);
    chk("fast_sclk@77", if_fast.ADC_clock, 1);
    chk("dut_sclk@77",  if_dut.ADC_clock, 0);
    at_neg(92);
    chk("fast_sync_n@92", if_fast.ADC_word_sync_n, 1);
    chk("fast_sclk@92",   if_fast.ADC_clock, 0);
    at_neg(93);
    chk("fast_sync_n@93", if_fast.ADC_word_sync_n, 0);
    at_neg(95);
    chk("fast_sclk_rises", rises_fast, 9);
    chk("fast_busy@95",    if_fast.busy, 0);
    tick_to(100);
    if_fast.enable = 1'b0;
    at_neg(110);
    chk("dut_sync_n@110",     if_dut.ADC_word_sync_n, 1);
    chk("ovr_overrun_cnt@110", if_ovr.overrun_cnt, 2);
    at_neg(111);
    chk("dut_sync_n@111", if_dut.ADC_word_sync_n, 0);
    chk("dut_sclk@111",   if_dut.ADC_clock, 0);
    at_neg(112);
    chk("dut_sync_n@112", if_dut.ADC_word_sync_n, 0);
    at_neg(113);
    chk("dut_sync_n@113",    if_dut.ADC_word_sync_n, 1);
    chk("dut_busy@113",      if_dut.busy, 0);
    chk("dut_sclk_rises_f1", rises_dut, 9);
    at_neg(114);
    chk("dut_sample_cnt@114", if_dut.sample_cnt, 1);
    at_neg(161);
    chk("ovr_adc_cnv@161", if_ovr.adc_cnv, 1);
    tick_to(170);
    if_ovr.enable = 1'b0;
    at_neg(200);
    chk("ovr_overrun@200",     if_ovr.overrun, 1);
    chk("ovr_overrun_cnt@200", if_ovr.overrun_cnt, 2);
    at_neg(265);
    chk("ovr_sample_cnt@265", if_ovr.sample_cnt, 2);
    tick_to(270);
    if_ovr.clr_err = 1'b1;
    tick_to(271);
    if_ovr.clr_err = 1'b0;
    at_neg(272);
    chk("ovr_overrun_clr",     if_ovr.overrun, 0);
    chk("ovr_overrun_cnt_clr", if_ovr.overrun_cnt, 0);

    // Continuous run: five frames, no overruns
    at_neg(914);
    chk("dut_sample_cnt@914", if_dut.sample_cnt, 5);
    chk("dut_overrun@914",    if_dut.overrun, 0);
    chk("dut_sclk_rises_f5",  rises_dut, 45);

    // enable dropped 20 cycles into the frame started by the tick at 1010
    tick_to(1030);
    if_dut.enable = 1'b0;
    push_exp(0, 1113, 6);
    at_neg(1032);
    chk("dut_period_cnt@1032", u_dut.r_period_cnt, 0);
    at_neg(1250);
    chk("dut_sample_cnt@1250", if_dut.sample_cnt, 6);
    chk("dut_cnv_rises@1250",  cnv_rises_dut, 6);
    chk("dut_busy@1250",       if_dut.busy, 0);
    chk("dut_period_cnt@1250", u_dut.r_period_cnt, 0);

    // Reset asserted between edges while ADC_clock is high in SHIFT
    tick_to(1299);
    if_dut.enable = 1'b1;
    at_neg(1370);
    chk("dut_sclk_pre_rst", if_dut.ADC_clock, 1);
    rst_n = 1'b0;
    #1;
    chk("dut_sclk_async_rst",   if_dut.ADC_clock, 0);
    chk("dut_sync_n_async_rst", if_dut.ADC_word_sync_n, 1);
    chk("dut_busy_async_rst",   if_dut.busy, 0);
    chk("dut_cnt_async_rst",    if_dut.sample_cnt, 0);
    tick_to(1375);
    rst_n = 1'b1;
    push_exp(0, 1479, 1);
    tick_to(1450);
    if_dut.enable = 1'b0;
    at_neg(1480);
    chk("dut_sample_cnt_post_rst", if_dut.sample_cnt, 1);

    at_neg(1500);
    chk("sb_pending_entries", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
